// File: rtl/jtag_dma_engine.sv
// DMA engine moving words between a ping-pong buffer and a bursting bus master.
// Transfers are split into bursts of at most burst_size+1 beats each.
module jtag_dma_engine #(
    parameter int BUF_AW = 9
) (
    input  logic              system_clk,
    input  logic              n_reset,
    input  logic              launch_write,
    input  logic              launch_read,
    input  logic              launch_simple_switch,
    input  logic [31:0]       address,
    input  logic [3:0]        byte_enable,
    input  logic [7:0]        burst_size,
    input  logic [7:0]        block_size_in,
    output logic              busy,
    output logic              operation_done,
    output logic              operation_error,
    output logic [7:0]        block_size_out,
    output logic [BUF_AW-1:0] buf_address,
    output logic              buf_writeEnable,
    output logic [31:0]       buf_dataIn,
    input  logic [31:0]       buf_dataOut,
    output logic              bus_request,
    input  logic              bus_grant,
    output logic              bus_begin_transaction,
    output logic [31:0]       bus_address_data,
    output logic              bus_read_n_write,
    output logic [3:0]        bus_byte_enables,
    output logic [7:0]        bus_burst_size,
    output logic              bus_data_valid,
    output logic              bus_end_transaction,
    input  logic [31:0]       bus_data_in,
    input  logic              bus_data_valid_in,
    input  logic              bus_busy_in,
    input  logic              bus_error_in,
    input  logic              bus_end_transaction_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_DATA,
        S_END,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_armed;
    logic        r_is_read;
    logic        r_error;
    logic        r_end_seen;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [7:0]  r_burst;
    logic [7:0]  r_remaining;
    logic [7:0]  r_beats;
    logic [7:0]  r_beat_cnt;
    logic [7:0]  r_index;
    logic [7:0]  r_bso;

    logic        w_launch;
    logic        w_launch_rd;
    logic        w_xfer;
    logic        w_beat_ok;
    logic        w_last;
    logic        w_end_ok;
    logic [8:0]  w_want;
    logic [7:0]  w_beats_calc;
    logic [7:0]  w_rem_next;
    logic [7:0]  w_buf_idx;

    // r_armed keeps the first edge after reset release from taking a launch
    assign w_launch    = r_armed &
                         (launch_write | launch_read | launch_simple_switch);
    assign w_launch_rd = ~launch_write & launch_read;
    assign w_xfer      = (launch_write | launch_read) &
                         (block_size_in != 8'd0);

    assign w_beat_ok = (r_state == S_DATA) & ~bus_error_in &
                       (r_is_read ? bus_data_valid_in : ~bus_busy_in);
    assign w_last    = (r_beat_cnt == r_beats - 8'd1);

    assign w_want       = {1'b0, r_burst} + 9'd1;
    assign w_beats_calc = (w_want < {1'b0, r_remaining}) ?
                          w_want[7:0] : r_remaining;
    assign w_rem_next   = r_remaining - r_beats;

    // an aborted read must not wait for an end the slave may never send
    assign w_end_ok = r_error | ~r_is_read | r_end_seen |
                      bus_end_transaction_in;

    always_ff @(posedge system_clk or negedge n_reset) begin
        if (!n_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_launch) w_next = w_xfer ? S_REQUEST : S_DONE;
            end
            S_REQUEST: begin
                if (bus_grant) w_next = S_BEGIN;
            end
            S_BEGIN: w_next = S_DATA;
            S_DATA: begin
                if (bus_error_in)           w_next = S_END;
                else if (w_beat_ok && w_last) w_next = S_END;
            end
            S_END: begin
                if (w_end_ok) begin
                    if (r_error || w_rem_next == 8'd0) w_next = S_DONE;
                    else                               w_next = S_REQUEST;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge n_reset) begin
        if (!n_reset) begin
            r_armed     <= 1'b0;
            r_is_read   <= 1'b0;
            r_error     <= 1'b0;
            r_end_seen  <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_burst     <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_beat_cnt  <= '0;
            r_index     <= '0;
            r_bso       <= '0;
        end else begin
            r_armed <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_addr      <= address;
                        r_be        <= byte_enable;
                        r_burst     <= burst_size;
                        r_remaining <= block_size_in;
                        r_is_read   <= w_launch_rd;
                        r_error     <= 1'b0;
                        r_end_seen  <= 1'b0;
                        r_index     <= '0;
                        if (w_launch_rd) r_bso <= '0;
                    end
                end
                S_BEGIN: begin
                    r_beats    <= w_beats_calc;
                    r_beat_cnt <= '0;
                    r_end_seen <= 1'b0;
                end
                S_DATA: begin
                    if (bus_error_in) begin
                        r_error <= 1'b1;
                    end else if (w_beat_ok) begin
                        r_index    <= r_index + 8'd1;
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                    if (bus_end_transaction_in) r_end_seen <= 1'b1;
                end
                S_END: begin
                    if (w_end_ok) begin
                        if (r_is_read && (r_error || w_rem_next == 8'd0))
                            r_bso <= r_index;
                        if (!r_error) begin
                            r_addr      <= r_addr +
                                           {22'd0, r_beats, 2'b00};
                            r_remaining <= w_rem_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign buf_address = BUF_AW'(w_buf_idx);

    always_comb begin
        busy                  = (r_state != S_IDLE);
        bus_request           = (r_state == S_REQUEST) |
                                (r_state == S_BEGIN) |
                                (r_state == S_DATA) |
                                (r_state == S_END);
        operation_done        = (r_state == S_DONE);
        operation_error       = r_error;
        block_size_out        = r_bso;
        w_buf_idx             = '0;
        buf_writeEnable       = 1'b0;
        buf_dataIn            = '0;
        bus_begin_transaction = 1'b0;
        bus_address_data      = '0;
        bus_read_n_write      = 1'b0;
        bus_byte_enables      = '0;
        bus_burst_size        = '0;
        bus_data_valid        = 1'b0;
        bus_end_transaction   = 1'b0;
        unique case (r_state)
            S_REQUEST: w_buf_idx = r_index;
            S_BEGIN: begin
                w_buf_idx             = r_index;
                bus_begin_transaction = 1'b1;
                bus_address_data      = r_addr;
                bus_read_n_write      = r_is_read;
                bus_byte_enables      = r_be;
                bus_burst_size        = w_beats_calc - 8'd1;
            end
            S_DATA: begin
                bus_byte_enables = r_be;
                if (r_is_read) begin
                    w_buf_idx       = r_index;
                    buf_writeEnable = w_beat_ok;
                    buf_dataIn      = w_beat_ok ? bus_data_in : '0;
                end else begin
                    // look one word ahead so the registered RAM keeps pace
                    w_buf_idx        = w_beat_ok ? r_index + 8'd1 : r_index;
                    bus_data_valid   = 1'b1;
                    bus_address_data = buf_dataOut;
                end
            end
            S_END: begin
                w_buf_idx           = r_index;
                bus_end_transaction = ~r_is_read;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/jtag_dma_engine.md
JTAG_DMA_ENGINE -- requirements
Module: jtag_dma_engine

Interface
REQ-001 SHALL have parameter: BUF_AW, 9, ping-pong buffer address width; only the low 8 bits are used, upper bits driven 0.
REQ-002 SHALL have ports:
- system_clk  in  1  sole clock.
- n_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports:
- launch_write  in  1  one-cycle pulse: copy buffer to bus.
- launch_read  in  1  one-cycle pulse: copy bus to buffer.
- launch_simple_switch  in  1  one-cycle pulse: no transfer, completion only.
REQ-004 SHALL have ports:
- address  in  32  start byte address, word aligned.
- byte_enable  in  4  per-beat byte enables.
- burst_size  in  8  beats per burst minus 1.
- block_size_in  in  8  words to transfer.
REQ-005 SHALL have ports:
- busy  out  1  engine active.
- operation_done  out  1  one-cycle completion pulse.
- operation_error  out  1  last operation aborted.
- block_size_out  out  8  valid words in buffer after a read.
REQ-006 SHALL have buffer ports:
- buf_address  out  BUF_AW  word index.
- buf_writeEnable  out  1  write strobe.
- buf_dataIn  out  32  write data.
- buf_dataOut  in  32  read data, 1-cycle registered-read latency.
REQ-007 SHALL have bus-master ports:
- bus_request  out  1  request bus.
- bus_grant  in  1  grant.
- bus_begin_transaction  out  1  address phase.
- bus_address_data  out  32  address in the address phase, data in the data phase.
- bus_read_n_write  out  1  1 = read.
- bus_byte_enables  out  4  byte enables.
- bus_burst_size  out  8  burst beats minus 1.
- bus_data_valid  out  1  write beat valid.
- bus_end_transaction  out  1  end of write burst.
- bus_data_in  in  32  read data.
- bus_data_valid_in  in  1  read beat valid.
- bus_busy_in  in  1  slave stall.
- bus_error_in  in  1  slave error.
- bus_end_transaction_in  in  1  end of read burst.

Function
REQ-008 SHALL implement states IDLE, REQUEST, BEGIN, DATA, END, DONE; busy SHALL be 1 in every state except IDLE.
REQ-009 In IDLE, a launch SHALL latch address, byte_enable, burst_size and block_size_in.
- Priority on simultaneous launches: write > read > simple_switch.
- Launch pulses arriving while busy=1 SHALL be ignored.
REQ-010 launch_simple_switch, or a write/read launch with block_size_in=0, SHALL go IDLE->DONE directly with no bus activity; block_size_out SHALL be 0 when the launch was a read.
REQ-011 A write/read launch with block_size_in!=0 SHALL go to REQUEST.
- REQUEST SHALL hold bus_request=1 until bus_grant=1, then go to BEGIN.
- bus_request SHALL stay 1 from REQUEST through END.
REQ-012 BEGIN SHALL last exactly one cycle and drive:
- bus_begin_transaction=1 and bus_address_data=current address.
- bus_read_n_write and bus_byte_enables.
- bus_burst_size = min(burst_size+1, remaining words) - 1.
REQ-013 Write DATA phase:
- bus_data_valid=1 and bus_address_data=buf_dataOut.
- A beat SHALL complete on a cycle with bus_busy_in=0.
- buf_address SHALL equal the current word index when the beat is not completing and index+1 when it is, so the next data is available the following cycle; BEGIN SHALL present the first index.
REQ-014 Read DATA phase:
- On each bus_data_valid_in=1: buf_writeEnable=1, buf_dataIn=bus_data_in, buf_address=word index, then index+1.
REQ-015 After the last beat of a burst, the engine SHALL go to END.
- Write: END drives bus_end_transaction=1 for one cycle.
- Read: END waits for bus_end_transaction_in=1; bus_end_transaction_in arriving in DATA together with the last beat SHALL satisfy END immediately.
REQ-016 Leaving END:
- Remaining words>0: address += 4*beats, remaining -= beats, go to REQUEST.
- Otherwise: go to DONE.
- Address arithmetic SHALL be 32-bit wrapping.
REQ-017 bus_error_in=1 in DATA SHALL abort the transfer:
- Go to END, then DONE.
- operation_error=1, held until the next launch.
- A read SHALL set block_size_out to the words already written.
REQ-018 DONE SHALL last one cycle with operation_done=1, then go to IDLE; block_size_out after a successful read SHALL equal block_size_in.
REQ-019 All bus and buffer strobes SHALL be 0 outside the states named above.

Reset
REQ-020 n_reset=0 SHALL, asynchronously:
- Force IDLE and zero all outputs and latched registers.
- Deassert bus_request immediately, even mid-burst, with no END issued.
REQ-021 Release of n_reset SHALL take effect on the next system_clk edge; no launch SHALL be accepted in the same cycle as release.

Verification
REQ-022 The bench SHALL cover:
- Write, block_size_in=5, burst_size=3, address=0x100: bursts of 4 then 1 beats at 0x100/0x110; buffer indices 0..4 in order; one operation_done.
- Read, block_size_in=3, burst_size=15, with a data-valid gap: buffer writes at indices 0,1,2; block_size_out=3; one operation_done.
- Write with bus_busy_in=1 for 3 cycles mid-burst: bus data held stable; no beat lost or duplicated.
- bus_error_in on beat 2 of a 4-word read: operation_error=1; block_size_out=1.
- launch_write and launch_read in the same cycle, then a launch_simple_switch while busy: write performed; the switch is ignored.
- n_reset asserted during DATA: bus_request=0 that cycle; all outputs 0; a later launch works normally.
